hpdcache_sram_rmw_ctrl: RTL and testbench



---
 rtl/hpdcache_rmw_pkg.sv | 24 ++
 rtl/hpdcache_rmw_merge.sv | 28 ++
 rtl/hpdcache_sram_rmw_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_hpdcache_sram_rmw_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_rmw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hpdcache_rmw_pkg
//  Description : Shared types and helpers for the HPDcache SRAM
//                read-modify-write controller (controller states and
//                byte-enable width derivation).
//  Revision    : 1.0 - initial release
// ============================================================================
package hpdcache_rmw_pkg;

    // Controller states: idle, read result pending, partial-write merge pending
    typedef enum logic [1:0] {
        RMW_IDLE  = 2'd0,
        RMW_RD    = 2'd1,
        RMW_MERGE = 2'd2
    } rmw_state_e;

    // Number of byte lanes in a data word of the given bit width
    function automatic int unsigned be_width(input int unsigned data_size);
        return data_size / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_rmw_merge.sv
`default_nettype none
// ============================================================================
//  Module      : hpdcache_rmw_merge
//  Description : Combinational byte merge. Each byte lane of the result takes
//                the new data when its byte enable is set, otherwise the old
//                data.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_rmw_merge
    import hpdcache_rmw_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0]   old_data,
    input  logic [DATA_SIZE-1:0]   new_data,
    input  logic [DATA_SIZE/8-1:0] be,
    output logic [DATA_SIZE-1:0]   merged_data
);

    localparam int unsigned c_BE_WIDTH = be_width(DATA_SIZE);

    // One multiplexer per byte lane
    for (genvar i = 0; i < c_BE_WIDTH; i++) begin : g_byte
        assign merged_data[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/hpdcache_sram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hpdcache_sram_rmw_ctrl
//  Description : Drives a 1RW SRAM macro without native byte enables and adds
//                byte-enable writes through read-modify-write. Full-mask
//                writes go straight to the macro, partial writes read the old
//                word first and write the merged word the next cycle.
//                Optional feature macro: HPDCACHE_RMW_FWD_EN (forwarding of
//                the last SRAM write to reads and partial writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_sram_rmw_ctrl
    import hpdcache_rmw_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_SIZE-1:0]   req_addr,
    input  logic [DATA_SIZE-1:0]   req_wdata,
    input  logic [DATA_SIZE/8-1:0] req_be,

    output logic                   rsp_valid,
    output logic [DATA_SIZE-1:0]   rsp_rdata,

    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [ADDR_SIZE-1:0]   sram_addr,
    output logic [DATA_SIZE-1:0]   sram_wdata,
    input  logic [DATA_SIZE-1:0]   sram_rdata
);

    localparam int unsigned c_BE_WIDTH = be_width(DATA_SIZE);

    localparam logic [1:0] c_ST_IDLE  = RMW_IDLE;
    localparam logic [1:0] c_ST_RD    = RMW_RD;
    localparam logic [1:0] c_ST_MERGE = RMW_MERGE;

    // The word count must fit in the address space
    if ((DEPTH < 1) || (DEPTH > (2**ADDR_SIZE))) begin : g_depth_invalid
        $error("hpdcache_sram_rmw_ctrl: DEPTH does not fit ADDR_SIZE");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [DATA_SIZE-1:0]  r_wdata;
    logic [c_BE_WIDTH-1:0] r_be;
    logic                  w_latch;
    logic                  w_be_full;
    logic                  w_be_any;
    logic [DATA_SIZE-1:0]  w_merged_sram;

    assign w_be_full = &req_be;
    assign w_be_any  = |req_be;

    // Merge of the latched partial write against the word read from the macro
    hpdcache_rmw_merge #(
        .DATA_SIZE   (DATA_SIZE)
    ) u_merge_sram (
        .old_data    (sram_rdata),
        .new_data    (r_wdata),
        .be          (r_be),
        .merged_data (w_merged_sram)
    );

`ifdef HPDCACHE_RMW_FWD_EN
    logic                  r_fwd_valid;
    logic [ADDR_SIZE-1:0]  r_fwd_addr;
    logic [DATA_SIZE-1:0]  r_fwd_data;
    logic                  r_rd_fwd;
    logic                  w_rd_fwd;
    logic                  w_fwd_hit;
    logic [DATA_SIZE-1:0]  w_merged_fwd;

    assign w_fwd_hit = r_fwd_valid && (r_fwd_addr == req_addr);

    // Merge of an incoming partial write against the forwarded word
    hpdcache_rmw_merge #(
        .DATA_SIZE   (DATA_SIZE)
    ) u_merge_fwd (
        .old_data    (r_fwd_data),
        .new_data    (req_wdata),
        .be          (req_be),
        .merged_data (w_merged_fwd)
    );

    // Track the last word written to the macro; a write in the reset cycle
    // cannot happen because the SRAM port is gated by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            r_rd_fwd    <= 1'b0;
        end else begin
            r_rd_fwd <= w_rd_fwd;
            if (sram_cs && sram_we) begin
                r_fwd_valid <= 1'b1;
                r_fwd_addr  <= sram_addr;
                r_fwd_data  <= sram_wdata;
            end
        end
    end
`endif

    // Next state, handshake, response and SRAM port decode
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = req_addr;
        sram_wdata  = req_wdata;
`ifdef HPDCACHE_RMW_FWD_EN
        w_rd_fwd    = 1'b0;
`endif
        if (!rst) begin
            case (r_state)
                c_ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (!req_we) begin
                            w_state_nxt = c_ST_RD;
`ifdef HPDCACHE_RMW_FWD_EN
                            if (w_fwd_hit) begin
                                w_rd_fwd = 1'b1;
                            end else begin
                                sram_cs = 1'b1;
                            end
`else
                            sram_cs = 1'b1;
`endif
                        end else if (w_be_full) begin
                            sram_cs = 1'b1;
                            sram_we = 1'b1;
                        end else if (w_be_any) begin
`ifdef HPDCACHE_RMW_FWD_EN
                            if (w_fwd_hit) begin
                                // Old word already known: merge and write now
                                sram_cs    = 1'b1;
                                sram_we    = 1'b1;
                                sram_wdata = w_merged_fwd;
                            end else begin
                                sram_cs     = 1'b1;
                                w_latch     = 1'b1;
                                w_state_nxt = c_ST_MERGE;
                            end
`else
                            sram_cs     = 1'b1;
                            w_latch     = 1'b1;
                            w_state_nxt = c_ST_MERGE;
`endif
                        end
                        // Zero-mask write: accepted with no macro access
                    end
                end
                c_ST_RD: begin
                    rsp_valid   = 1'b1;
`ifdef HPDCACHE_RMW_FWD_EN
                    rsp_rdata   = r_rd_fwd ? r_fwd_data : sram_rdata;
`else
                    rsp_rdata   = sram_rdata;
`endif
                    w_state_nxt = c_ST_IDLE;
                end
                c_ST_MERGE: begin
                    sram_cs     = 1'b1;
                    sram_we     = 1'b1;
                    sram_addr   = r_addr;
                    sram_wdata  = w_merged_sram;
                    w_state_nxt = c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // State register and partial-write capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_sram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpdcache_sram_rmw_ctrl
//  Description : Self-checking bench for hpdcache_sram_rmw_ctrl with a
//                behavioural 1RW SRAM and a read-response scoreboard.
//                Honours HPDCACHE_RMW_FWD_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdcache_sram_rmw_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW/8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    hpdcache_sram_rmw_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .DEPTH     (2**AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1RW SRAM, read data valid one cycle after a read select
    logic [DW-1:0] sram_mem [2**AW];
    logic [DW-1:0] ref_mem  [2**AW];
    int n_sram_rd = 0;
    int n_sram_wr = 0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_cs) begin
            if (sram_we) begin
                sram_mem[sram_addr] <= sram_wdata;
                n_sram_wr <= n_sram_wr + 1;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
                n_sram_rd <= n_sram_rd + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard: every response must match the oldest outstanding read
    always @(negedge clk) begin
        if (!rst) begin
            n_checks = n_checks + 1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_errors = n_errors + 1;
                    $display("FAIL rsp_unexpected: got data %h, required no response", rsp_rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e.data || cyc != e.due) begin
                        n_errors = n_errors + 1;
                        $display("FAIL rsp_data: got %h at cycle %0d, required %h at cycle %0d",
                                 rsp_rdata, cyc, e.data, e.due);
                    end
                end
            end else if (rsp_rdata !== '0) begin
                n_errors = n_errors + 1;
                $display("FAIL rsp_idle_zero: got %h, required 0", rsp_rdata);
            end
        end
    end

    function automatic logic [DW-1:0] ref_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                                input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Observations taken at the accepting cycle
    int            acc_wait;
    logic          acc_cs;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    // Drive one request, wait (bounded) for acceptance, update the reference
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be);
        int w;
        exp_t e;
        w = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: req_ready stayed %b, required 1", req_ready);
        end
        acc_wait = w; acc_cs = sram_cs; acc_we = sram_we; acc_addr = sram_addr; acc_wdata = sram_wdata;
        if (!we) begin
            e.data = ref_mem[a]; e.due = cyc + 1;
            exp_q.push_back(e);
        end else begin
            ref_mem[a] = ref_merge(ref_mem[a], d, be);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_cycles(2);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || sram_cs !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: ready=%b cs=%b rsp_valid=%b rdata=%h, required 0 0 0 0",
                     req_ready, sram_cs, rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_write_read;
        int rd0, wr0;
        rd0 = n_sram_rd; wr0 = n_sram_wr;
        send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        n_checks++;
        if (acc_cs !== 1'b1 || acc_we !== 1'b1 || acc_addr !== 8'h10 || acc_wdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL full_write_port: cs=%b we=%b addr=%h data=%h, required 1 1 10 deadbeef",
                     acc_cs, acc_we, acc_addr, acc_wdata);
        end
        n_checks++;
        if (n_sram_rd - rd0 != 0 || n_sram_wr - wr0 != 1) begin
            n_errors++;
            $display("FAIL full_write_count: reads=%0d writes=%0d, required 0 1",
                     n_sram_rd - rd0, n_sram_wr - wr0);
        end
        send(1'b0, 8'h10, 32'h0, 4'h0);
        n_checks++;
`ifdef HPDCACHE_RMW_FWD_EN
        if (acc_wait != 0 || acc_cs !== 1'b0) begin
`else
        if (acc_wait != 0 || acc_cs !== 1'b1 || acc_we !== 1'b0) begin
`endif
            n_errors++;
            $display("FAIL read_issue: wait=%0d cs=%b we=%b", acc_wait, acc_cs, acc_we);
        end
        idle_cycles(2);
    endtask

    task automatic test_partial_write;
        int rd0;
        rd0 = n_sram_rd;
        send(1'b1, 8'h10, 32'h000000AA, 4'b0001);
`ifdef HPDCACHE_RMW_FWD_EN
        n_checks++;
        if (acc_cs !== 1'b1 || acc_we !== 1'b1 || acc_wdata !== 32'hDEADBEAA || n_sram_rd != rd0) begin
            n_errors++;
            $display("FAIL fwd_partial_hit: cs=%b we=%b data=%h reads=%0d, required 1 1 deadbeaa 0",
                     acc_cs, acc_we, acc_wdata, n_sram_rd - rd0);
        end
`else
        n_checks++;
        if (acc_cs !== 1'b1 || acc_we !== 1'b0 || acc_addr !== 8'h10) begin
            n_errors++;
            $display("FAIL partial_read_phase: cs=%b we=%b addr=%h, required 1 0 10", acc_cs, acc_we, acc_addr);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || sram_cs !== 1'b1 || sram_we !== 1'b1 ||
            sram_addr !== 8'h10 || sram_wdata !== 32'hDEADBEAA) begin
            n_errors++;
            $display("FAIL partial_merge_phase: ready=%b cs=%b we=%b addr=%h data=%h, required 0 1 1 10 deadbeaa",
                     req_ready, sram_cs, sram_we, sram_addr, sram_wdata);
        end
        @(posedge clk); #1;
`endif
        send(1'b0, 8'h10, 32'h0, 4'h0);
        n_checks++;
        if (acc_wait != 0) begin
            n_errors++;
            $display("FAIL read_after_merge_wait: got %0d, required 0", acc_wait);
        end
        idle_cycles(2);
    endtask

    task automatic test_zero_mask;
        int wr0, rd0;
        wr0 = n_sram_wr; rd0 = n_sram_rd;
        send(1'b1, 8'h20, 32'h55555555, 4'h0);
        n_checks++;
        if (acc_wait != 0 || acc_cs !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_mask_accept: wait=%0d cs=%b, required 0 0", acc_wait, acc_cs);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || sram_cs !== 1'b0 || n_sram_wr != wr0 || n_sram_rd != rd0) begin
            n_errors++;
            $display("FAIL zero_mask_after: ready=%b cs=%b accesses=%0d, required 1 0 0",
                     req_ready, sram_cs, (n_sram_wr - wr0) + (n_sram_rd - rd0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int wr0;
        logic [DW-1:0] d;
        wr0 = n_sram_wr;
        for (int i = 1; i <= 4; i++) begin
            d = 32'hA0B0C000 + 32'(i);
            send(1'b1, 8'(i), d, 4'hF);
            n_checks++;
            if (acc_wait != 0 || acc_cs !== 1'b1 || acc_we !== 1'b1 ||
                acc_addr !== 8'(i) || acc_wdata !== d) begin
                n_errors++;
                $display("FAIL b2b_write_%0d: wait=%0d cs=%b we=%b addr=%h data=%h, required 0 1 1 %h %h",
                         i, acc_wait, acc_cs, acc_we, acc_addr, acc_wdata, 8'(i), d);
            end
        end
        n_checks++;
        if (n_sram_wr - wr0 != 4) begin
            n_errors++;
            $display("FAIL b2b_write_count: got %0d, required 4", n_sram_wr - wr0);
        end
        for (int i = 1; i <= 4; i++) begin
            send(1'b0, 8'(i), 32'h0, 4'h0);
            n_checks++;
            if (acc_wait != ((i == 1) ? 0 : 1)) begin
                n_errors++;
                $display("FAIL b2b_read_wait_%0d: got %0d, required %0d", i, acc_wait, (i == 1) ? 0 : 1);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_in_merge;
        logic [DW-1:0] saved;
        send(1'b1, 8'h30, 32'h12345678, 4'hF);
        send(1'b1, 8'h31, 32'h0BADF00D, 4'hF);
        saved = ref_mem[8'h30];
        send(1'b1, 8'h30, 32'h0000AB00, 4'b0010);
        ref_mem[8'h30] = saved;
        n_checks++;
        if (acc_cs !== 1'b1 || acc_we !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_merge_read: cs=%b we=%b, required 1 0", acc_cs, acc_we);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sram_cs !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_merge_outputs: cs=%b rsp_valid=%b ready=%b, required 0 0 0",
                     sram_cs, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || sram_cs !== 1'b0 || sram_mem[8'h30] !== 32'h12345678) begin
            n_errors++;
            $display("FAIL rst_merge_after: ready=%b cs=%b mem=%h, required 1 0 12345678",
                     req_ready, sram_cs, sram_mem[8'h30]);
        end
        @(posedge clk); #1;
        send(1'b0, 8'h30, 32'h0, 4'h0);
        idle_cycles(2);
    endtask

`ifdef HPDCACHE_RMW_FWD_EN
    task automatic test_forwarding;
        int rd0;
        send(1'b1, 8'h40, 32'h11223344, 4'hF);
        send(1'b0, 8'h40, 32'h0, 4'h0);
        n_checks++;
        if (acc_cs !== 1'b0) begin
            n_errors++;
            $display("FAIL fwd_read_cs: got %b, required 0", acc_cs);
        end
        idle_cycles(1);
        rd0 = n_sram_rd;
        send(1'b1, 8'h40, 32'hFF000000, 4'b1000);
        n_checks++;
        if (acc_cs !== 1'b1 || acc_we !== 1'b1 || acc_wdata !== 32'hFF223344 || n_sram_rd != rd0) begin
            n_errors++;
            $display("FAIL fwd_partial: cs=%b we=%b data=%h reads=%0d, required 1 1 ff223344 0",
                     acc_cs, acc_we, acc_wdata, n_sram_rd - rd0);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL fwd_partial_occupancy: ready=%b, required 1", req_ready);
        end
        @(posedge clk); #1;
        send(1'b0, 8'h40, 32'h0, 4'h0);
        idle_cycles(2);
    endtask
`endif

    task automatic test_final;
        int bad;
        idle_cycles(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
        end
        bad = 0;
        for (int a = 0; a < 2**AW; a++) if (sram_mem[a] !== ref_mem[a]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL memory_image: %0d words differ, required 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        sram_rdata = '0;
        for (int a = 0; a < 2**AW; a++) begin
            sram_mem[a] = '0;
            ref_mem[a]  = '0;
        end
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_zero_mask();
        test_back_to_back();
        test_reset_in_merge();
`ifdef HPDCACHE_RMW_FWD_EN
        test_forwarding();
`endif
        test_final();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
